mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the single-port 256x16 RAM between the CPU and a second bus master (switch loader / debug port). Each master issues commands with the CPU memory encoding: 00 none, 01 read, 10 write, 11 illegal. The arbiter grants one access at a time, round-robin, and drives the RAM's address, write-data and write-enable. It returns read data and an ack pulse to the granted master. Addresses with bit 8 set are outside the RAM; they are rejected with an error ack and are never forwarded to the RAM.

---
 rtl/mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares one single-port 256x16 synchronous RAM between master A (CPU) and
// master B (switch loader / debug port). Each access takes three cycles:
// IDLE (grant + capture) -> ACCESS (RAM address/data/write driven) -> RESP
// (one-cycle ack to the winner, read data latched at the closing edge).
// Ties are broken round-robin. Addresses with the top bit set, and the
// illegal command 11, are acked with an error and never reach the RAM.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   a_cmd/a_addr/a_wdata     master A request (00 none, 01 rd, 10 wr, 11 illegal)
//   a_ack/a_err/a_rdata      master A completion pulse, error flag, read data
//   b_*                      same set for master B
//   ram_addr/ram_din         registered RAM address / write data
//   ram_write                RAM write enable, high only in the ACCESS cycle
//   ram_dout                 RAM read data, valid the cycle after the address
//   busy                     high whenever the arbiter is not IDLE
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    a_cmd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic [1:0]    b_cmd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic [AW-2:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // A request is refused when the command is illegal or the address lies
  // outside the RAM (top address bit set).
  function automatic logic is_rejected(input logic [1:0] cmd, input logic oor);
    return (cmd == CMD_ILLEGAL) || oor;
  endfunction

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          win_q, win_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          oor_q, oor_d;
  logic [AW-2:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_write_q, ram_write_d;
  logic          a_ack_q, a_ack_d;
  logic          a_err_q, a_err_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic          b_ack_q, b_ack_d;
  logic          b_err_q, b_err_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          busy_q, busy_d;

  logic          a_pend;
  logic          b_pend;
  logic          grant_b;
  logic [1:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Winner selection: a lone requester wins; on a tie the port that was not
  // granted last wins.
  always_comb begin
    a_pend = (a_cmd != CMD_NONE);
    b_pend = (b_cmd != CMD_NONE);
    if (a_pend && b_pend) begin
      grant_b = (last_grant_q == PORT_A);
    end else begin
      grant_b = b_pend;
    end
    if (grant_b) begin
      sel_cmd   = b_cmd;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end else begin
      sel_cmd   = a_cmd;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
  end

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    cmd_d        = cmd_q;
    oor_d        = oor_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_write_d  = 1'b0;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    b_rdata_d    = b_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (a_pend || b_pend) begin
          win_d        = grant_b;
          last_grant_d = grant_b;
          cmd_d        = sel_cmd;
          oor_d        = sel_addr[AW-1];
          // RAM address/data are captured here so they are stable for the
          // whole ACCESS cycle and hold until the next grant.
          ram_addr_d   = sel_addr[AW-2:0];
          ram_din_d    = sel_wdata;
          ram_write_d  = (sel_cmd == CMD_WRITE) && !sel_addr[AW-1];
          state_d      = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (win_q == PORT_B) begin
          b_ack_d = 1'b1;
          b_err_d = is_rejected(cmd_q, oor_q);
        end else begin
          a_ack_d = 1'b1;
          a_err_d = is_rejected(cmd_q, oor_q);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // ram_dout now holds the word sampled at the edge that closed ACCESS.
        if ((cmd_q == CMD_READ) && !oor_q) begin
          if (win_q == PORT_B) begin
            b_rdata_d = ram_dout;
          end else begin
            a_rdata_d = ram_dout;
          end
        end else begin
          a_rdata_d = a_rdata_q;
          b_rdata_d = b_rdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_B;
      win_q        <= PORT_A;
      cmd_q        <= CMD_NONE;
      oor_q        <= 1'b0;
      ram_addr_q   <= {(AW-1){1'b0}};
      ram_din_q    <= {DW{1'b0}};
      ram_write_q  <= 1'b0;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      a_rdata_q    <= {DW{1'b0}};
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      b_rdata_q    <= {DW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      cmd_q        <= cmd_d;
      oor_q        <= oor_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_write_q  <= ram_write_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      a_rdata_q    <= a_rdata_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_ack     = b_ack_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_write = ram_write_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural 256x16 synchronous RAM, directed
// scenarios and a randomized run checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    a_cmd, b_cmd;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-2:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_write, busy;
  logic          ram_clr;

  logic [DW-1:0] ram_mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] ref_a_rdata, ref_b_rdata;
  logic          ref_last;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 16'(i * 3 + 1);
    end else if (ram_write) begin
      ram_mem[ram_addr] <= ram_din;
    end
    ram_dout <= ram_mem[ram_addr];
  end

  // Drive one request on a port from an IDLE negedge and wait (bounded) for
  // its ack; reports latency, error flag and any RAM writes seen.
  task automatic issue(input logic port, input logic [1:0] cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output logic got, output logic err,
                       output int lat, output int nwr, output logic [AW-2:0] wa,
                       output logic [DW-1:0] wdat);
    got = 1'b0; err = 1'b0; lat = 0; nwr = 0; wa = 8'h00; wdat = 16'h0000;
    if (port) begin b_cmd = cmd; b_addr = addr; b_wdata = wd; end
    else begin a_cmd = cmd; a_addr = addr; a_wdata = wd; end
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (ram_write === 1'b1) begin nwr++; wa = ram_addr; wdat = ram_din; end
      if ((port ? b_ack : a_ack) === 1'b1) begin
        got = 1'b1; lat = i; err = port ? b_err : a_err;
      end
    end
    if (port) b_cmd = 2'b00; else a_cmd = 2'b00;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ref_a_rdata = 16'h0000; ref_b_rdata = 16'h0000; ref_last = 1'b1;
  endtask

  task automatic test_reset();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    a_cmd = 2'b00; b_cmd = 2'b00; a_addr = 9'h000; b_addr = 9'h000;
    a_wdata = 16'h0000; b_wdata = 16'h0000; ram_clr = 1'b1;
    reset = 1'b1; #1; reset = 1'b0;
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    vectors++;
    if ({busy, a_ack, b_ack, a_err, b_err, ram_write} !== 6'b000000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, a_ack, b_ack, a_err, b_err, ram_write});
    end
    vectors++;
    if ({a_rdata, b_rdata, ram_addr, ram_din} !== 56'h0) begin
      miscompares++; $display("FAIL reset_data: got %h expected 0", {a_rdata, b_rdata, ram_addr, ram_din});
    end
    reset = 1'b1;
    a_cmd = 2'b10; a_addr = 9'h010; a_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if (ram_write !== 1'b1) begin
      miscompares++; $display("FAIL reset_pre_write: got %b expected 1", ram_write);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({ram_write, busy, a_ack, b_ack} !== 4'b0000 || a_rdata !== 16'h0000) begin
      miscompares++; $display("FAIL reset_midwrite: got wr/busy/acks %b rdata %h expected 0000 0000", {ram_write, busy, a_ack, b_ack}, a_rdata);
    end
    a_cmd = 2'b00;
    @(negedge clk);
    vectors++;
    if ({a_ack, busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_noack: got %b expected 00", {a_ack, busy});
    end
    reset = 1'b1;
    // The interrupted write must not have reached the RAM.
    issue(1'b0, 2'b01, 9'h010, 16'h0000, g, e, l, nw, wa, wd);
    vectors++;
    if (!g || e !== 1'b0 || a_rdata !== ref_mem[8'h10]) begin
      miscompares++; $display("FAIL reset_aborted_write: got ack %b err %b rdata %h expected 1 0 %h", g, e, a_rdata, ref_mem[8'h10]);
    end
    ref_a_rdata = ref_mem[8'h10];
  endtask

  task automatic test_write_read();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    issue(1'b0, 2'b10, 9'h005, 16'hABCD, g, e, l, nw, wa, wd);
    ref_mem[8'h05] = 16'hABCD;
    vectors++;
    if (!g || l != 2 || e !== 1'b0) begin
      miscompares++; $display("FAIL wr_ack: got ack %b lat %0d err %b expected 1 2 0", g, l, e);
    end
    vectors++;
    if (nw != 1 || wa !== 8'h05 || wd !== 16'hABCD) begin
      miscompares++; $display("FAIL wr_ram: got %0d writes addr %h data %h expected 1 05 abcd", nw, wa, wd);
    end
    issue(1'b0, 2'b01, 9'h005, 16'h0000, g, e, l, nw, wa, wd);
    vectors++;
    if (!g || l != 2 || e !== 1'b0 || nw != 0) begin
      miscompares++; $display("FAIL rd_ack: got ack %b lat %0d err %b writes %0d expected 1 2 0 0", g, l, e, nw);
    end
    vectors++;
    if (a_rdata !== 16'hABCD) begin
      miscompares++; $display("FAIL rd_data: got %h expected abcd", a_rdata);
    end
    ref_a_rdata = 16'hABCD;
  endtask

  task automatic test_out_of_range();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    issue(1'b1, 2'b10, 9'h0FF, 16'h1357, g, e, l, nw, wa, wd);
    ref_mem[8'hFF] = 16'h1357;
    vectors++;
    if (!g || e !== 1'b0 || nw != 1) begin
      miscompares++; $display("FAIL oor_prewrite: got ack %b err %b writes %0d expected 1 0 1", g, e, nw);
    end
    issue(1'b1, 2'b10, 9'h1FF, 16'h5555, g, e, l, nw, wa, wd);
    vectors++;
    if (!g || l != 2 || e !== 1'b1) begin
      miscompares++; $display("FAIL oor_err: got ack %b lat %0d err %b expected 1 2 1", g, l, e);
    end
    vectors++;
    if (nw != 0 || b_rdata !== ref_b_rdata) begin
      miscompares++; $display("FAIL oor_nowrite: got writes %0d rdata %h expected 0 %h", nw, b_rdata, ref_b_rdata);
    end
    issue(1'b1, 2'b01, 9'h0FF, 16'h0000, g, e, l, nw, wa, wd);
    vectors++;
    if (!g || b_rdata !== 16'h1357) begin
      miscompares++; $display("FAIL oor_ram_intact: got ack %b rdata %h expected 1 1357", g, b_rdata);
    end
    ref_b_rdata = 16'h1357;
  endtask

  task automatic test_illegal();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    issue(1'b0, 2'b11, 9'h005, 16'h9999, g, e, l, nw, wa, wd);
    vectors++;
    if (!g || l != 2 || e !== 1'b1 || nw != 0) begin
      miscompares++; $display("FAIL illegal_err: got ack %b lat %0d err %b writes %0d expected 1 2 1 0", g, l, e, nw);
    end
    vectors++;
    if (a_rdata !== ref_a_rdata) begin
      miscompares++; $display("FAIL illegal_rdata: got %h expected %h", a_rdata, ref_a_rdata);
    end
  endtask

  task automatic test_tie();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    int a_at, b_at, ea_at, eb_at; logic a_e, b_e;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        // A lone A grant makes A the last winner, so the following tie goes to B.
        issue(1'b0, 2'b01, 9'h005, 16'h0000, g, e, l, nw, wa, wd);
        vectors++;
        if (!g) begin miscompares++; $display("FAIL tie_single: got ack %b expected 1", g); end
      end
      a_at = 0; b_at = 0; a_e = 1'b0; b_e = 1'b0;
      a_cmd = 2'b01; a_addr = 9'h005; b_cmd = 2'b01; b_addr = 9'h0FF;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (a_ack === 1'b1) begin a_at = i; a_e = a_err; a_cmd = 2'b00; end
        if (b_ack === 1'b1) begin b_at = i; b_e = b_err; b_cmd = 2'b00; end
      end
      a_cmd = 2'b00; b_cmd = 2'b00;
      ea_at = (r == 0) ? 2 : 5;
      eb_at = (r == 0) ? 5 : 2;
      vectors++;
      if (a_at != ea_at || b_at != eb_at) begin
        miscompares++; $display("FAIL tie_order_%0d: got A@%0d B@%0d expected A@%0d B@%0d", r, a_at, b_at, ea_at, eb_at);
      end
      vectors++;
      if ({a_e, b_e} !== 2'b00) begin
        miscompares++; $display("FAIL tie_err_%0d: got %b expected 00", r, {a_e, b_e});
      end
      vectors++;
      if (a_rdata !== ref_mem[8'h05] || b_rdata !== ref_mem[8'hFF]) begin
        miscompares++; $display("FAIL tie_data_%0d: got %h %h expected %h %h", r, a_rdata, b_rdata, ref_mem[8'h05], ref_mem[8'hFF]);
      end
    end
    ref_a_rdata = ref_mem[8'h05]; ref_b_rdata = ref_mem[8'hFF];
  endtask

  task automatic test_contention();
    logic g, e; int l, nw; logic [AW-2:0] wa; logic [DW-1:0] wd;
    logic [DW-1:0] d, expa, expb; logic pa, pb; logic [7:0] seq;
    int ai, bi, n, idle_run, max_idle;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      issue(1'b0, 2'b10, 9'(32 + i), d, g, e, l, nw, wa, wd);
      ref_mem[8'(32 + i)] = d;
      d = 16'($urandom);
      issue(1'b1, 2'b10, 9'(64 + i), d, g, e, l, nw, wa, wd);
      ref_mem[8'(64 + i)] = d;
    end
    apply_reset();
    ai = 0; bi = 0; n = 0; idle_run = 0; max_idle = 0; pa = 1'b0; pb = 1'b0;
    seq = 8'h00; expa = 16'h0000; expb = 16'h0000;
    a_cmd = 2'b01; a_addr = 9'h020; b_cmd = 2'b01; b_addr = 9'h040;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (pa) begin
        vectors++; pa = 1'b0;
        if (a_rdata !== expa) begin miscompares++; $display("FAIL cont_a_data: got %h expected %h", a_rdata, expa); end
      end
      if (pb) begin
        vectors++; pb = 1'b0;
        if (b_rdata !== expb) begin miscompares++; $display("FAIL cont_b_data: got %h expected %h", b_rdata, expb); end
      end
      if (busy === 1'b0) idle_run++; else idle_run = 0;
      if (idle_run > max_idle) max_idle = idle_run;
      if (a_ack === 1'b1) begin
        if (n < 8) seq[n] = 1'b0;
        n++; expa = ref_mem[8'(32 + ai)]; pa = 1'b1; ai++; a_addr = 9'(32 + ai);
      end
      if (b_ack === 1'b1) begin
        if (n < 8) seq[n] = 1'b1;
        n++; expb = ref_mem[8'(64 + bi)]; pb = 1'b1; bi++; b_addr = 9'(64 + bi);
      end
    end
    a_cmd = 2'b00; b_cmd = 2'b00;
    @(negedge clk);
    vectors++;
    if (n != 4 || seq[3:0] !== 4'b1010) begin
      miscompares++; $display("FAIL cont_order: got %0d acks seq %b expected 4 acks seq 1010", n, seq[3:0]);
    end
    vectors++;
    if (max_idle > 1) begin
      miscompares++; $display("FAIL cont_busy: got idle run %0d expected at most 1", max_idle);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cd; logic m_win; logic [1:0] m_cmd; logic [AW-1:0] m_addr; logic [DW-1:0] m_wd;
    logic ea, eb, ew, eerr; int v;
    apply_reset();
    cd = 0; m_win = 1'b0; m_cmd = 2'b00; m_addr = 9'h000; m_wd = 16'h0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      // cd counts the cycles left in the current access: 2 = RAM cycle,
      // 1 = response cycle, 0 = idle.
      ea   = (cd == 1) && !m_win;
      eb   = (cd == 1) && m_win;
      ew   = (cd == 2) && (m_cmd == 2'b10) && !m_addr[AW-1];
      eerr = (m_cmd == 2'b11) || m_addr[AW-1];
      vectors++;
      if ({busy, a_ack, b_ack, ram_write} !== {cd != 0, ea, eb, ew}) begin
        miscompares++;
        $display("FAIL rnd_ctrl cyc %0d: got busy/a_ack/b_ack/wr %b expected %b", cyc, {busy, a_ack, b_ack, ram_write}, {cd != 0, ea, eb, ew});
      end
      if (ea || eb) begin
        vectors++;
        if ((ea ? a_err : b_err) !== eerr) begin
          miscompares++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, ea ? a_err : b_err, eerr);
        end
      end
      vectors++;
      if ({a_rdata, b_rdata} !== {ref_a_rdata, ref_b_rdata}) begin
        miscompares++; $display("FAIL rnd_rdata cyc %0d: got %h %h expected %h %h", cyc, a_rdata, b_rdata, ref_a_rdata, ref_b_rdata);
      end
      if (cd != 0) begin
        vectors++;
        if ({ram_addr, ram_din} !== {m_addr[AW-2:0], m_wd}) begin
          miscompares++; $display("FAIL rnd_ram cyc %0d: got %h %h expected %h %h", cyc, ram_addr, ram_din, m_addr[AW-2:0], m_wd);
        end
      end
      if (cd == 1 && m_cmd == 2'b01 && !m_addr[AW-1]) begin
        if (m_win) ref_b_rdata = ref_mem[m_addr[7:0]];
        else ref_a_rdata = ref_mem[m_addr[7:0]];
      end
      // Masters: new command only when idle or in the cycle their ack is seen.
      if (ea || (a_cmd == 2'b00 && $urandom_range(0, 2) == 0)) begin
        if (ea && $urandom_range(0, 1) == 0) a_cmd = 2'b00;
        else begin
          v = $urandom_range(0, 9);
          a_cmd = (v < 5) ? 2'b01 : ((v < 9) ? 2'b10 : 2'b11);
          a_addr = {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 15))};
          a_wdata = 16'($urandom);
        end
      end
      if (eb || (b_cmd == 2'b00 && $urandom_range(0, 2) == 0)) begin
        if (eb && $urandom_range(0, 1) == 0) b_cmd = 2'b00;
        else begin
          v = $urandom_range(0, 9);
          b_cmd = (v < 5) ? 2'b01 : ((v < 9) ? 2'b10 : 2'b11);
          b_addr = {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 15))};
          b_wdata = 16'($urandom);
        end
      end
      if (cd == 0) begin
        if (a_cmd != 2'b00 || b_cmd != 2'b00) begin
          m_win = (a_cmd != 2'b00 && b_cmd != 2'b00) ? ~ref_last : (b_cmd != 2'b00);
          ref_last = m_win;
          m_cmd  = m_win ? b_cmd : a_cmd;
          m_addr = m_win ? b_addr : a_addr;
          m_wd   = m_win ? b_wdata : a_wdata;
          if (m_cmd == 2'b10 && !m_addr[AW-1]) ref_mem[m_addr[7:0]] = m_wd;
          cd = 2;
        end
      end else begin
        cd--;
      end
    end
    a_cmd = 2'b00; b_cmd = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 3 + 1);
    ref_a_rdata = 16'h0000; ref_b_rdata = 16'h0000; ref_last = 1'b1;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_illegal();
    apply_reset();
    test_tie();
    test_contention();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
